// File: rtl/issue_scoreboard_pkg.sv
// Shared register-name / opcode package for the VLIW decode stage and its issue scoreboard.
// Holds name widths, the null register, opcode encodings and the slot bundle layout.
package issue_scoreboard_pkg;

    localparam int RW     = 4;
    localparam int IW     = 4;
    localparam int NSLOTS = 3;

    localparam logic [RW-1:0] REG0 = '0;

    typedef enum logic [IW-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_STORE = 4'h6,
        OP_BR    = 4'h7
    } opcode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [RW-1:0] dest;
        logic [RW-1:0] srca;
        logic [RW-1:0] srcb;
    } slot_t;

    // Slot 0 is the bundle's first slot, which sits in the most significant field.
    function automatic slot_t unpack_slot(
        input logic [NSLOTS*IW-1:0] inst,
        input logic [NSLOTS*RW-1:0] dest,
        input logic [NSLOTS*RW-1:0] srca,
        input logic [NSLOTS*RW-1:0] srcb,
        input int                   idx
    );
        slot_t s;
        s.inst = inst[(NSLOTS-idx)*IW-1 -: IW];
        s.dest = dest[(NSLOTS-idx)*RW-1 -: RW];
        s.srca = srca[(NSLOTS-idx)*RW-1 -: RW];
        s.srcb = srcb[(NSLOTS-idx)*RW-1 -: RW];
        return s;
    endfunction

endpackage

// File: rtl/issue_scoreboard_sb_slot_check.sv
// Hazard check for one decode slot: an active slot conflicts when either source
// or its non-null destination has a pending write in the scoreboard.
module sb_slot_check
    import issue_scoreboard_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  slot_t            slot,
    input  logic [NREGS-1:0] busy_map,
    output logic             active,
    output logic             slot_hazard
);

    logic raw_hit;
    logic waw_hit;

    assign active      = (slot.inst != OP_NOP);
    assign raw_hit     = busy_map[slot.srca] | busy_map[slot.srcb];
    assign waw_hit     = (slot.dest != REG0) & busy_map[slot.dest];
    assign slot_hazard = active & (raw_hit | waw_hit);

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller for the 3-slot VLIW decode stage: per-register write scoreboard,
// RAW/WAW stall, and post-branch flush sequencing. ISSUE_STALL_CNT_EN adds a stall counter.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREGS        = 16,
    parameter int LOAD_LAT     = 2,
    parameter int ALU_LAT      = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bnd_valid,
    input  logic [NSLOTS*IW-1:0] bnd_inst,
    input  logic [NSLOTS*RW-1:0] bnd_dest,
    input  logic [NSLOTS*RW-1:0] bnd_srca,
    input  logic [NSLOTS*RW-1:0] bnd_srcb,
    input  logic                 br_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [NREGS-1:0]     busy_map,
    output logic                 err_dup,
    output logic [31:0]          stall_cnt
);

    localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int FW      = $clog2(FLUSH_CYCLES + 1);

    slot_t              slot     [NSLOTS];
    logic [CW-1:0]      slot_lat [NSLOTS];
    logic [NSLOTS-1:0]  active;
    logic [NSLOTS-1:0]  slot_hazard;
    logic               issue;
    logic               dup_dest;

    issue_state_e       state, state_n;
    logic [FW-1:0]      fcnt, fcnt_n;

    // ---------------------------------------------------------------- slots
    for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
        assign slot[s]     = unpack_slot(bnd_inst, bnd_dest, bnd_srca, bnd_srcb, s);
        assign slot_lat[s] = (slot[s].inst == OP_LOAD) ? CW'(LOAD_LAT) : CW'(ALU_LAT);

        sb_slot_check #(.NREGS(NREGS)) u_check (
            .slot        (slot[s]),
            .busy_map    (busy_map),
            .active      (active[s]),
            .slot_hazard (slot_hazard[s])
        );
    end

    assign stall = bnd_valid & (state == ST_RUN) & (|slot_hazard);
    assign issue = bnd_valid & (state == ST_RUN) & ~stall & ~br_taken;

    // ----------------------------------------------------------- scoreboard
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_null
            assign busy_map[r] = 1'b0;
        end else begin : g_cnt
            logic [CW-1:0] cnt;
            logic          wr_en;
            logic [CW-1:0] wr_lat;

            // Duplicate writers to one register keep it busy until the longest completes.
            // NOTE: every always_comb output gets a default first so no latch is inferred.
            always_comb begin
                wr_en  = 1'b0;
                wr_lat = '0;
                for (int s = 0; s < NSLOTS; s++) begin
                    if (issue && active[s] && (slot[s].dest == RW'(r))) begin
                        wr_en = 1'b1;
                        if (slot_lat[s] > wr_lat) wr_lat = slot_lat[s];
                    end
                end
            end

            // NOTE: sequential state uses non-blocking assignment; each counter is a plain
            // flop with reset (not a memory), since busy_map must read all-clear after reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt <= '0;
                end else if (wr_en) begin
                    cnt <= wr_lat;
                end else if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end

            assign busy_map[r] = (cnt != '0);
        end
    end

    // ------------------------------------------------------ duplicate dests
    always_comb begin
        dup_dest = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            for (int j = i + 1; j < NSLOTS; j++) begin
                if (active[i] && active[j] && (slot[i].dest == slot[j].dest) &&
                    (slot[i].dest != REG0)) begin
                    dup_dest = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_dup <= 1'b0;
        end else if (issue && dup_dest) begin
            err_dup <= 1'b1;
        end
    end

    // ------------------------------------------------------------ flush FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    // A branch seen while already flushing restarts the full flush window.
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        case (state)
            ST_RUN: begin
                if (br_taken) begin
                    state_n = ST_FLUSH;
                    fcnt_n  = FW'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    fcnt_n = FW'(FLUSH_CYCLES);
                end else if (fcnt == FW'(1)) begin
                    state_n = ST_RUN;
                    fcnt_n  = '0;
                end else begin
                    fcnt_n = fcnt - FW'(1);
                end
            end
            default: begin
                state_n = ST_RUN;
                fcnt_n  = '0;
            end
        endcase
    end

    assign flush = (state == ST_FLUSH);

    // -------------------------------------------------------- stall counter
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized bundles
// checked against a time-stamp model (each register's free cycle, the flush end cycle).
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int NREGS        = 16;
    localparam int LOAD_LAT     = 2;
    localparam int ALU_LAT      = 1;
    localparam int FLUSH_CYCLES = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 bnd_valid;
    logic [NSLOTS*IW-1:0] bnd_inst;
    logic [NSLOTS*RW-1:0] bnd_dest;
    logic [NSLOTS*RW-1:0] bnd_srca;
    logic [NSLOTS*RW-1:0] bnd_srcb;
    logic                 br_taken;
    logic                 stall;
    logic                 flush;
    logic [NREGS-1:0]     busy_map;
    logic                 err_dup;
    logic [31:0]          stall_cnt;

    always #5 clock = ~clock;

    issue_scoreboard #(
        .NREGS(NREGS), .LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .bnd_valid(bnd_valid), .bnd_inst(bnd_inst),
        .bnd_dest(bnd_dest), .bnd_srca(bnd_srca), .bnd_srcb(bnd_srcb), .br_taken(br_taken),
        .stall(stall), .flush(flush), .busy_map(busy_map), .err_dup(err_dup),
        .stall_cnt(stall_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: absolute cycle stamps instead of counters.
    int now = 0;
    int free_at [NREGS];
    int flush_end = 0;
    bit m_err = 1'b0;
    int m_stalls = 0;

    // ---------------------------------------------------------- stimulus helpers
    task automatic set_slot(input int s, input logic [IW-1:0] op, input int d, input int a,
                            input int b);
        bnd_inst[(4-s)*IW-1 -: IW] = op;
        bnd_dest[(4-s)*RW-1 -: RW] = RW'(d);
        bnd_srca[(4-s)*RW-1 -: RW] = RW'(a);
        bnd_srcb[(4-s)*RW-1 -: RW] = RW'(b);
    endtask

    task automatic clear_bundle();
        bnd_valid = 1'b0;
        bnd_inst  = '0;
        bnd_dest  = '0;
        bnd_srca  = '0;
        bnd_srcb  = '0;
    endtask

    function automatic logic [IW-1:0] op_of(input int s);
        return bnd_inst[(4-s)*IW-1 -: IW];
    endfunction
    function automatic int dest_of(input int s); return int'(bnd_dest[(4-s)*RW-1 -: RW]); endfunction
    function automatic int srca_of(input int s); return int'(bnd_srca[(4-s)*RW-1 -: RW]); endfunction
    function automatic int srcb_of(input int s); return int'(bnd_srcb[(4-s)*RW-1 -: RW]); endfunction

    // ------------------------------------------------------------------ model
    function automatic bit m_busy(input int r);
        return (r != 0) && (now < free_at[r]);
    endfunction

    function automatic bit m_flushing();
        return now < flush_end;
    endfunction

    function automatic bit m_stall();
        bit h = 1'b0;
        if (!bnd_valid || m_flushing()) return 1'b0;
        for (int s = 1; s <= 3; s++)
            if (op_of(s) != OP_NOP && (m_busy(srca_of(s)) || m_busy(srcb_of(s)) || m_busy(dest_of(s))))
                h = 1'b1;
        return h;
    endfunction

    function automatic logic [NREGS-1:0] m_map();
        logic [NREGS-1:0] m;
        for (int r = 0; r < NREGS; r++) m[r] = m_busy(r);
        return m;
    endfunction

    // Advance the model across one rising edge, using the inputs currently driven.
    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) free_at[r] = 0;
            flush_end = 0;
            m_err     = 1'b0;
            m_stalls  = 0;
        end else begin
            bit st = m_stall();
            if (st) m_stalls++;
            if (bnd_valid && !m_flushing() && !st && !br_taken) begin
                for (int s = 1; s <= 3; s++) begin
                    int d = dest_of(s);
                    int lat = (op_of(s) == OP_LOAD) ? LOAD_LAT : ALU_LAT;
                    if (op_of(s) != OP_NOP && d != 0 && free_at[d] < now + 1 + lat)
                        free_at[d] = now + 1 + lat;
                    for (int t = s + 1; t <= 3; t++)
                        if (op_of(s) != OP_NOP && op_of(t) != OP_NOP && d != 0 && d == dest_of(t))
                            m_err = 1'b1;
                end
            end
            if (br_taken) flush_end = now + 1 + FLUSH_CYCLES;
        end
        now++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        clear_bundle();
        br_taken = 1'b0;
        repeat (n) tick();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        clear_bundle();
        br_taken = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; #1;
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", flush); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (busy_map !== '0) begin miscompares++; $display("FAIL reset_busy: got %h want 0", busy_map); end
        vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end

        // Build up busy regs, a sticky error and an active flush, then reset mid-flush.
        bnd_valid = 1'b1;
        set_slot(1, OP_LOAD, 3, 1, 2);
        set_slot(3, OP_ADD, 3, 4, 5);
        #1; tick();
        clear_bundle();
        br_taken = 1'b1;
        #1; tick();
        br_taken  = 1'b0;
        bnd_valid = 1'b1;
        set_slot(2, OP_ADD, 6, 3, 0);
        #1;
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL premid_flush: got %b want 1", flush); end
        vectors++; if (err_dup !== 1'b1) begin miscompares++; $display("FAIL premid_err_dup: got %b want 1", err_dup); end
        vectors++; if (busy_map[3] !== 1'b1) begin miscompares++; $display("FAIL premid_busy_r3: got %b want 1", busy_map[3]); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL premid_stall: got %b want 0", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL midreset_flush: got %b want 0", flush); end
        vectors++; if (busy_map !== '0) begin miscompares++; $display("FAIL midreset_busy: got %h want 0", busy_map); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL midreset_stall: got %b want 0", stall); end
        vectors++; if (err_dup !== 1'b0) begin miscompares++; $display("FAIL midreset_err_dup: got %b want 0", err_dup); end
        idle(4);
    endtask

    task automatic test_load_use();
        reset = 1'b1;
        clear_bundle();
        tick();
        reset = 1'b0;
        bnd_valid = 1'b1;
        set_slot(1, OP_LOAD, 3, 1, 2);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load_issue_stall: got %b want 0", stall); end
        tick();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(1, OP_ADD, 4, 3, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (stall !== (i < 2)) begin miscompares++; $display("FAIL load_use_stall c%0d: got %b want %b", i, stall, (i < 2)); end
            vectors++; if (busy_map[3] !== (i < 2)) begin miscompares++; $display("FAIL load_use_busy_r3 c%0d: got %b want %b", i, busy_map[3], (i < 2)); end
            tick();
        end
        clear_bundle(); #1;
        vectors++; if (busy_map[4] !== 1'b1) begin miscompares++; $display("FAIL load_use_issued_r4: got %b want 1", busy_map[4]); end
`ifdef ISSUE_STALL_CNT_EN
        vectors++; if (stall_cnt !== 32'd2) begin miscompares++; $display("FAIL load_use_stall_cnt: got %0d want 2", stall_cnt); end
`else
        vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL load_use_stall_cnt_off: got %0d want 0", stall_cnt); end
`endif
        tick(); #1;
        vectors++; if (busy_map[4] !== 1'b0) begin miscompares++; $display("FAIL load_use_r4_free: got %b want 0", busy_map[4]); end
        idle(3);
    endtask

    task automatic test_waw();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(3, OP_ADD, 5, 1, 2);
        #1; tick();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(1, OP_SUB, 5, 0, 0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b want 1", stall); end
        tick(); #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_release: got %b want 0", stall); end
        tick();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(2, OP_ADD, 0, 6, 0);
        #1;
        vectors++; if (busy_map[5] !== 1'b1) begin miscompares++; $display("FAIL waw_r5_busy: got %b want 1", busy_map[5]); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reg0_dest_stall: got %b want 0", stall); end
        vectors++; if (busy_map[0] !== 1'b0) begin miscompares++; $display("FAIL busy_r0: got %b want 0", busy_map[0]); end
        idle(3);
    endtask

    task automatic test_flush();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(1, OP_LOAD, 3, 0, 0);
        #1; tick();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(2, OP_ADD, 9, 3, 0);
        br_taken = 1'b1;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL br_cycle_stall: got %b want 1", stall); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_cycle_flush: got %b want 0", flush); end
        tick();
        br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL flush_hold c%0d: got %b want 1", i, flush); end
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall c%0d: got %b want 0", i, stall); end
            vectors++; if (busy_map[9] !== 1'b0) begin miscompares++; $display("FAIL flush_no_issue c%0d: got %b want 0", i, busy_map[9]); end
            tick();
        end
        #1;
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL flush_end: got %b want 0", flush); end
        idle(3);
    endtask

    task automatic test_flush_extend();
        int n = 0;
        clear_bundle();
        br_taken = 1'b1;
        #1; tick();
        #1;
        if (flush === 1'b1) n++;
        tick();
        br_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (flush === 1'b1) n++;
            tick();
        end
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL flush_extend_len: got %0d want 3", n); end
        idle(2);
    endtask

    task automatic test_dup();
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(1, OP_ADD, 0, 1, 2);
        set_slot(3, OP_SUB, 0, 1, 2);
        #1; tick(); #1;
        vectors++; if (err_dup !== 1'b0) begin miscompares++; $display("FAIL dup_reg0_err: got %b want 0", err_dup); end
        clear_bundle();
        bnd_valid = 1'b1;
        set_slot(1, OP_ADD, 7, 0, 0);
        set_slot(3, OP_LOAD, 7, 0, 0);
        #1; tick();
        clear_bundle(); #1;
        vectors++; if (err_dup !== 1'b1) begin miscompares++; $display("FAIL dup_err_set: got %b want 1", err_dup); end
        vectors++; if (busy_map[7] !== 1'b1) begin miscompares++; $display("FAIL dup_issued_r7: got %b want 1", busy_map[7]); end
        repeat (4) tick();
        #1;
        vectors++; if (err_dup !== 1'b1) begin miscompares++; $display("FAIL dup_err_sticky: got %b want 1", err_dup); end
    endtask

    task automatic test_random();
        reset = 1'b1;
        clear_bundle();
        br_taken = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bnd_valid = ($urandom_range(0, 9) < 8);
            br_taken  = ($urandom_range(0, 11) == 0);
            for (int s = 1; s <= 3; s++)
                set_slot(s, IW'($urandom_range(0, 3)), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            vectors++; if (stall !== m_stall()) begin miscompares++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, m_stall()); end
            vectors++; if (flush !== m_flushing()) begin miscompares++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush, m_flushing()); end
            vectors++; if (busy_map !== m_map()) begin miscompares++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy_map, m_map()); end
            vectors++; if (err_dup !== m_err) begin miscompares++; $display("FAIL rnd_err_dup c%0d: got %b want %b", c, err_dup, m_err); end
`ifdef ISSUE_STALL_CNT_EN
            vectors++; if (stall_cnt !== 32'(m_stalls)) begin miscompares++; $display("FAIL rnd_stall_cnt c%0d: got %0d want %0d", c, stall_cnt, m_stalls); end
`else
            vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL rnd_stall_cnt_off c%0d: got %0d want 0", c, stall_cnt); end
`endif
            tick();
        end
        idle(2);
    endtask

    initial begin
        reset    = 1'b1;
        br_taken = 1'b0;
        clear_bundle();
        for (int r = 0; r < NREGS; r++) free_at[r] = 0;
        test_reset();
        test_load_use();
        test_waw();
        test_flush();
        test_flush_extend();
        test_dup();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
